// File: rtl/measure_unit_mc_regs.sv
// Wishbone register front end for up to 8 measurement channels: deltas, strobe
// control, masked DAC threshold broadcast, run enables and a shared point FIFO.
module measure_unit_mc_regs #(
   parameter int          NUM_CH                   = 2,
   parameter int          FIFO_DEPTH               = 16,
   parameter int          PERIOD_WIDTH             = 27,
   parameter logic [9:0]  DEFAULT_DELAY_CODE_DELTA = 10'h1,
   parameter logic [15:0] DEFAULT_THRESHOLD_DELTA  = 16'h1
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [31:0]              wb_dat_i,
   output logic [31:0]              wb_dat_o,
   input  logic [31:0]              wb_adr_i,
   input  logic                     wb_we_i,
   input  logic [3:0]               wb_sel_i,
   input  logic                     wb_cyc_i,
   input  logic                     wb_stb_i,
   output logic                     wb_ack_o,
   output logic [15:0]              thr_delta_o,
   output logic [9:0]               dcode_delta_o,
   output logic [NUM_CH-1:0]        ch_run_o,
   output logic [15:0]              dac_code_o,
   output logic [NUM_CH-1:0]        dac_wre_o,
   input  logic [NUM_CH-1:0]        dac_rdy_i,
   output logic                     stb_run_o,
   output logic [2:0]               stb_sel_o,
   input  logic                     stb_rdy_i,
   input  logic                     stb_err_i,
   input  logic [PERIOD_WIDTH-1:0]  stb_period_i,
   input  logic [NUM_CH-1:0]        point_rdy_i,
   input  logic [16*NUM_CH-1:0]     point_v_i,
   input  logic [10*NUM_CH-1:0]     point_t_i,
   output logic                     irq_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int EW = 29;

   // Bus handshake: ack follows cyc&stb by one cycle and never repeats back
   // to back; every side effect (write, pop, clear-on-read) fires on ack only.
   logic        r_ack;
   logic [31:0] r_dat;
   logic [3:0]  w_word;
   logic        w_req, w_acc, w_wr, w_rd;
   logic        w_unused;

   assign w_word   = wb_adr_i[5:2];
   assign w_unused = ^{wb_adr_i[31:6], wb_adr_i[1:0]};
   assign w_req    = wb_cyc_i & wb_stb_i;
   assign w_acc    = w_req & r_ack;
   assign w_wr     = w_acc & wb_we_i;
   assign w_rd     = w_acc & ~wb_we_i;

   logic [15:0]       r_thr_delta, r_dac_code;
   logic [9:0]        r_dcode_delta;
   logic [7:0]        r_thr_mask;
   logic [2:0]        r_stb_sel;
   logic              r_stb_run, r_ovf, r_irq;
   logic [NUM_CH-1:0] r_dac_wre, r_skip, r_run;
   logic [1:0]        r_irq_en;

   logic [EW-1:0]     r_mem [FIFO_DEPTH];
   logic [AW:0]       r_wp, r_rp, w_cnt;
   logic [8:0]        w_cnt9;
   logic [7:0]        w_cnt8, w_mask8;
   logic              w_empty, w_full, w_push, w_pop, w_flush, w_drop;
   logic [EW-1:0]     w_head;

   logic [NUM_CH-1:0] r_slot_vld, w_free, w_mask;
   logic [15:0]       r_slot_v [NUM_CH];
   logic [9:0]        r_slot_t [NUM_CH];
   logic [SW-1:0]     w_sel;
   logic [31:0]       w_cur, w_wdat, w_rdat;

   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_cnt   = r_wp - r_rp;
   assign w_cnt9  = 9'(w_cnt);
   assign w_cnt8  = w_cnt9[8] ? 8'hFF : w_cnt9[7:0];
   assign w_head  = r_mem[r_rp[AW-1:0]];
   assign w_pop   = w_rd & (w_word == 4'd5) & ~w_empty;
   assign w_flush = w_wr & (w_word == 4'd3) & w_wdat[31];
   assign w_mask8 = (w_wdat[31:24] == 8'd0) ? 8'hFF : w_wdat[31:24];
   assign w_mask  = w_mask8[NUM_CH-1:0];

   // Current contents per address, used to merge unselected byte lanes.
   always_comb begin
      w_cur = '0;
      case (w_word)
         4'd0: w_cur = {6'd0, r_dcode_delta, r_thr_delta};
         4'd1: w_cur = {28'd0, r_stb_sel, 1'b0};
         4'd2: w_cur = {r_thr_mask, 8'd0, r_dac_code};
         4'd3: w_cur = 32'(r_run);
         4'd6: w_cur = {30'd0, r_irq_en};
         default: w_cur = '0;
      endcase
      for (int b = 0; b < 4; b++)
         w_wdat[8*b +: 8] = wb_sel_i[b] ? wb_dat_i[8*b +: 8] : w_cur[8*b +: 8];
   end

   always_comb begin
      w_rdat = '0;
      case (w_word)
         4'd0: w_rdat = {6'd0, r_dcode_delta, r_thr_delta};
         4'd1: w_rdat = {27'(stb_period_i), stb_err_i, r_stb_sel, stb_rdy_i};
         4'd2: w_rdat = {16'd0, 8'(r_skip), 8'(dac_rdy_i)};
         4'd3: w_rdat = 32'(r_run);
         4'd4: w_rdat = {15'd0, r_ovf, w_cnt8, 6'd0, w_full, w_empty};
         4'd5: w_rdat = w_empty ? 32'd0 : {1'b1, 2'b00, w_head};
         4'd6: w_rdat = {30'd0, r_irq_en};
         default: w_rdat = '0;
      endcase
   end

   // Lowest occupied pending slot wins the single FIFO push per cycle.
   always_comb begin
      w_sel = '0;
      for (int k = NUM_CH - 1; k >= 0; k--)
         if (r_slot_vld[k]) w_sel = SW'(k);
   end

   assign w_push = (|r_slot_vld) & (~w_full | w_pop);
   assign w_free = w_push ? (NUM_CH'(1) << w_sel) : '0;
   assign w_drop = |(point_rdy_i & r_slot_vld & ~w_free);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack         <= 1'b0;
         r_dat         <= '0;
         r_thr_delta   <= DEFAULT_THRESHOLD_DELTA;
         r_dcode_delta <= DEFAULT_DELAY_CODE_DELTA;
         r_dac_code    <= '0;
         r_thr_mask    <= '0;
         r_dac_wre     <= '0;
         r_skip        <= '0;
         r_stb_sel     <= '0;
         r_stb_run     <= 1'b0;
         r_run         <= '0;
         r_ovf         <= 1'b0;
         r_irq_en      <= '0;
         r_irq         <= 1'b0;
      end else begin
         r_ack     <= w_req & ~r_ack;
         r_dac_wre <= '0;
         r_stb_run <= w_wr & (w_word == 4'd1) & w_wdat[0];
         r_irq     <= (r_irq_en[0] & ~w_empty) | (r_irq_en[1] & r_ovf);
         if (w_req & ~r_ack & ~wb_we_i) r_dat <= w_rdat;
         if (w_wr && w_word == 4'd0) begin
            if (w_wdat[15:0] != 16'd0)  r_thr_delta   <= w_wdat[15:0];
            if (w_wdat[25:16] != 10'd0) r_dcode_delta <= w_wdat[25:16];
         end
         if (w_wr && w_word == 4'd1 && {29'd0, w_wdat[3:1]} < NUM_CH)
            r_stb_sel <= w_wdat[3:1];
         if (w_wr && w_word == 4'd2) begin
            r_dac_code <= w_wdat[15:0];
            r_thr_mask <= w_wdat[31:24];
            r_dac_wre  <= w_mask & dac_rdy_i;
            r_skip     <= r_skip | (w_mask & ~dac_rdy_i);
         end else if (w_rd && w_word == 4'd2) begin
            r_skip <= '0;
         end
         if (w_wr && w_word == 4'd3) r_run <= w_wdat[NUM_CH-1:0];
         if (w_drop)
            r_ovf <= 1'b1;
         else if (w_wr && w_word == 4'd4 && w_wdat[16])
            r_ovf <= 1'b0;
         if (w_wr && w_word == 4'd6) r_irq_en <= w_wdat[1:0];
      end
   end

   // Pointers and slot occupancy; flush overrides any push/pop that cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || w_flush) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_slot_vld <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         for (int k = 0; k < NUM_CH; k++) begin
            if (point_rdy_i[k] && (!r_slot_vld[k] || w_free[k]))
               r_slot_vld[k] <= 1'b1;
            else if (w_free[k])
               r_slot_vld[k] <= 1'b0;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (w_push)
         r_mem[r_wp[AW-1:0]] <= {3'(w_sel), r_slot_t[w_sel], r_slot_v[w_sel]};
      for (int k = 0; k < NUM_CH; k++) begin
         if (point_rdy_i[k] && (!r_slot_vld[k] || w_free[k])) begin
            r_slot_v[k] <= point_v_i[16*k +: 16];
            r_slot_t[k] <= point_t_i[10*k +: 10];
         end
      end
   end

   assign wb_ack_o      = r_ack;
   assign wb_dat_o      = r_dat;
   assign thr_delta_o   = r_thr_delta;
   assign dcode_delta_o = r_dcode_delta;
   assign ch_run_o      = r_run;
   assign dac_code_o    = r_dac_code;
   assign dac_wre_o     = r_dac_wre;
   assign stb_run_o     = r_stb_run;
   assign stb_sel_o     = r_stb_sel;
   assign irq_o         = r_irq;

endmodule

// File: tb/tb_measure_unit_mc_regs.sv
// Bench for measure_unit_mc_regs with four channels: register access, DAC
// broadcast, strobe control, point capture through the FIFO, IRQ and flush.
module tb_measure_unit_mc_regs;
   localparam int NUM_CH     = 4;
   localparam int FIFO_DEPTH = 16;
   localparam int PW         = 27;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [31:0]            wb_dat_i, wb_dat_o, wb_adr;
   logic                   wb_we, wb_cyc, wb_stb, wb_ack;
   logic [3:0]             wb_sel;
   logic [15:0]            thr_delta, dac_code;
   logic [9:0]             dcode_delta;
   logic [NUM_CH-1:0]      ch_run, dac_wre, dac_rdy, point_rdy;
   logic                   stb_run, stb_rdy, stb_err, irq;
   logic [2:0]             stb_sel;
   logic [PW-1:0]          stb_period;
   logic [16*NUM_CH-1:0]   point_v;
   logic [10*NUM_CH-1:0]   point_t;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] rd;

   measure_unit_mc_regs #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .PERIOD_WIDTH(PW)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_adr_i(wb_adr), .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_cyc_i(wb_cyc),
      .wb_stb_i(wb_stb), .wb_ack_o(wb_ack), .thr_delta_o(thr_delta),
      .dcode_delta_o(dcode_delta), .ch_run_o(ch_run), .dac_code_o(dac_code),
      .dac_wre_o(dac_wre), .dac_rdy_i(dac_rdy), .stb_run_o(stb_run),
      .stb_sel_o(stb_sel), .stb_rdy_i(stb_rdy), .stb_err_i(stb_err),
      .stb_period_i(stb_period), .point_rdy_i(point_rdy), .point_v_i(point_v),
      .point_t_i(point_t), .irq_o(irq)
   );

   // Clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Driver tasks: all start and end 1 time unit after a rising edge.
   task automatic wb_xfer(input bit we, input logic [3:0] word, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic [31:0] rdat);
      int n;
      wb_adr = {26'd0, word, 2'b00};
      wb_dat_i = wdat;
      wb_we = we;
      wb_sel = sel;
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!wb_ack && n < 8);
      check("ack_latency", n, 1);
      rdat = wb_dat_o;
      @(posedge clk); #1;
      check("ack_single", {31'd0, wb_ack}, 32'd0);
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we = 1'b0;
   endtask

   task automatic wb_write(input logic [3:0] word, input logic [31:0] wdat);
      logic [31:0] dummy;
      wb_xfer(1'b1, word, wdat, 4'hF, dummy);
   endtask

   task automatic wb_read(input logic [3:0] word, output logic [31:0] rdat);
      wb_xfer(1'b0, word, 32'd0, 4'hF, rdat);
   endtask

   // Scoreboard side: every FIFO read is compared to the queue head (0 if empty).
   task automatic read_fifo(input string tag);
      logic [31:0] got, exp;
      wb_read(4'd5, got);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
      check(tag, got, exp);
   endtask

   task automatic pulse_pt(input int ch, input logic [15:0] v, input logic [9:0] t, input bit keep);
      point_v[16*ch +: 16] = v;
      point_t[10*ch +: 10] = t;
      point_rdy = NUM_CH'(1) << ch;
      if (keep) exp_q.push_back({1'b1, 2'b00, 3'(ch), t, v});
      @(posedge clk); #1;
      point_rdy = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] rst_tab [7];
      logic [15:0] v;
      logic [9:0]  t;
      rst_tab = '{32'h0001_0001, 32'd0, 32'd0, 32'd0, 32'h1, 32'd0, 32'd0};
      rst = 1'b1;
      wb_dat_i = '0; wb_adr = '0; wb_we = 1'b0; wb_sel = 4'hF;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      dac_rdy = '0; stb_rdy = 1'b0; stb_err = 1'b0; stb_period = '0;
      point_rdy = '0; point_v = '0; point_t = '0;
      idle(3);
      check("rst_ack", {31'd0, wb_ack}, 32'd0);
      check("rst_thr_delta", thr_delta, 32'h1);
      check("rst_dcode_delta", dcode_delta, 32'h1);
      check("rst_misc", {dac_wre, ch_run, stb_run, irq, dac_code}, 32'd0);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      idle(1);
      rst = 1'b0;
      idle(1);

      for (int i = 0; i < 7; i++) begin
         wb_read(4'(i), rd);
         check($sformatf("rst_reg%0d", i), rd, rst_tab[i]);
      end

      // Delta register: zero field keeps old value, byte lanes merge.
      wb_write(4'd0, 32'h0000_0005);
      check("delta_thr", thr_delta, 32'd5);
      check("delta_dcode_kept", dcode_delta, 32'd1);
      begin
         logic [31:0] dummy;
         wb_xfer(1'b1, 4'd0, 32'h0003_0000, 4'b0100, dummy);
      end
      wb_read(4'd0, rd);
      check("delta_lane_merge", rd, 32'h0003_0005);

      // Masked threshold broadcast.
      dac_rdy = 4'b1011;
      wb_write(4'd2, 32'h0600_1234);
      check("thr_wre_pulse", dac_wre, 32'b0010);
      check("thr_code", dac_code, 32'h1234);
      idle(1);
      check("thr_wre_end", dac_wre, 32'd0);
      wb_read(4'd2, rd);
      check("thr_skip", rd, {16'd0, 8'h04, 8'h0B});
      wb_read(4'd2, rd);
      check("thr_skip_clr", rd, {16'd0, 8'h00, 8'h0B});

      // Strobe control.
      wb_write(4'd1, 32'h0000_000F);
      check("stb_run_pulse", {31'd0, stb_run}, 32'd1);
      check("stb_sel_ignored", stb_sel, 32'd0);
      idle(1);
      check("stb_run_end", {31'd0, stb_run}, 32'd0);
      wb_write(4'd1, 32'h0000_0004);
      check("stb_sel_set", stb_sel, 32'd2);
      stb_period = 27'd1000;
      stb_rdy = 1'b1;
      wb_read(4'd1, rd);
      check("stb_read", rd, {27'd1000, 1'b0, 3'd2, 1'b1});

      // Two simultaneous points drain lowest channel first.
      point_v[15:0] = 16'hAAAA; point_t[9:0] = 10'd3;
      point_v[47:32] = 16'h5555; point_t[29:20] = 10'd7;
      point_rdy = 4'b0101;
      exp_q.push_back(32'h8003_AAAA);
      exp_q.push_back(32'h8807_5555);
      idle(1);
      point_rdy = '0;
      idle(3);
      wb_read(4'd4, rd);
      check("cap_status", rd, 32'h0000_0200);
      read_fifo("cap_pop0");
      read_fifo("cap_pop1");
      read_fifo("cap_empty");

      // Fill FIFO plus the pending slot, then one dropped point.
      for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
         v = 16'($urandom_range(0, 65535));
         t = 10'($urandom_range(0, 1023));
         pulse_pt(1, v, t, 1'b1);
         idle(1);
      end
      idle(2);
      wb_read(4'd4, rd);
      check("ovf_full", rd, {15'd0, 1'b0, 8'(FIFO_DEPTH), 6'd0, 1'b1, 1'b0});
      pulse_pt(1, 16'hDEAD, 10'h155, 1'b0);
      idle(2);
      wb_read(4'd4, rd);
      check("ovf_set", rd, {15'd0, 1'b1, 8'(FIFO_DEPTH), 6'd0, 1'b1, 1'b0});
      for (int i = 0; i < FIFO_DEPTH + 1; i++)
         read_fifo($sformatf("drain%0d", i));
      read_fifo("drain_empty");
      wb_read(4'd4, rd);
      check("drain_status", rd, 32'h0001_0001);
      wb_write(4'd4, 32'h0001_0000);
      wb_read(4'd4, rd);
      check("ovf_clear", rd, 32'h0000_0001);

      // Not-empty interrupt: one cycle behind the FIFO push.
      wb_write(4'd6, 32'h1);
      check("irq_idle", {31'd0, irq}, 32'd0);
      pulse_pt(3, 16'h0F0F, 10'h2AA, 1'b1);
      check("irq_slot", {31'd0, irq}, 32'd0);
      idle(1);
      check("irq_push", {31'd0, irq}, 32'd0);
      idle(1);
      check("irq_rise", {31'd0, irq}, 32'd1);
      read_fifo("irq_pop");
      check("irq_hold", {31'd0, irq}, 32'd1);
      idle(1);
      check("irq_fall", {31'd0, irq}, 32'd0);

      // Occupied slot drops the new point; then flush keeps overflow.
      wb_write(4'd6, 32'h2);
      point_v[15:0] = 16'h1111; point_t[9:0] = 10'd1;
      point_v[31:16] = 16'h2222; point_t[19:10] = 10'd2;
      point_rdy = 4'b0011;
      idle(1);
      point_v[31:16] = 16'h3333; point_t[19:10] = 10'd9;
      point_rdy = 4'b0010;
      idle(1);
      point_rdy = '0;
      exp_q.push_back(32'h8001_1111);
      exp_q.push_back(32'h8402_2222);
      pulse_pt(2, 16'h4444, 10'd4, 1'b1);
      idle(3);
      wb_read(4'd4, rd);
      check("pre_flush_status", rd, 32'h0001_0300);
      check("irq_ovf", {31'd0, irq}, 32'd1);
      read_fifo("keep_old_ch0");
      wb_write(4'd3, 32'h8000_0005);
      exp_q.delete();
      check("ctl_run", ch_run, 32'h5);
      wb_read(4'd4, rd);
      check("flush_status", rd, 32'h0001_0001);
      wb_read(4'd3, rd);
      check("ctl_read", rd, 32'h5);
      read_fifo("flush_empty");
      check("irq_after_flush", {31'd0, irq}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
